// File: rtl/if_exec_controller_pkg.sv
// Shared types and defaults for the instruction-fetch execution controller.
package if_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP      = 3'd2,
    STEP_WAIT = 3'd3,
    DRAIN     = 3'd4,
    HALTED    = 3'd5
  } ctrl_state_e;

  localparam logic [31:0] HALT_OPCODE_DEF  = 32'hFFFF_FFFF;
  localparam int          DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/if_exec_controller_if.sv
// Command/fetch-side bundle of the execution controller.
// o_cycle_count exists only when IF_EXEC_CYCLE_COUNT_EN is defined.
interface if_exec_controller_if #(
  parameter int NB_INSTRUCTION = 32
`ifdef IF_EXEC_CYCLE_COUNT_EN
  , parameter int NB_CYCLE_CNT = 32
`endif
);
  logic                      i_program_loaded;
  logic                      i_run;
  logic                      i_step;
  logic                      i_restart;
  logic [NB_INSTRUCTION-1:0] i_instruction;
  logic                      o_pc_enable;
  logic                      o_pc_reset;
  logic                      o_read_enable;
  logic                      o_pipeline_enable;
  logic                      o_halted;
  logic                      o_busy;
`ifdef IF_EXEC_CYCLE_COUNT_EN
  logic [NB_CYCLE_CNT-1:0]   o_cycle_count;
`endif

  // master: debug unit / fetch stage side; slave: the controller
  modport master (
    output i_program_loaded, i_run, i_step, i_restart, i_instruction,
    input  o_pc_enable, o_pc_reset, o_read_enable, o_pipeline_enable, o_halted, o_busy
`ifdef IF_EXEC_CYCLE_COUNT_EN
    , input o_cycle_count
`endif
  );

  modport slave (
    input  i_program_loaded, i_run, i_step, i_restart, i_instruction,
    output o_pc_enable, o_pc_reset, o_read_enable, o_pipeline_enable, o_halted, o_busy
`ifdef IF_EXEC_CYCLE_COUNT_EN
    , output o_cycle_count
`endif
  );
endinterface

// File: rtl/if_exec_controller_drain_counter.sv
// Loadable down-counter with a zero flag; stops at zero. Also used for UART byte counts.
module drain_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear)          count <= '0;
    else if (load)             count <= load_value;
    else if (dec && !zero)     count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/if_exec_controller.sv
// Fetch/pipeline sequencer: run, single-step, HALT detect and drain. Moore outputs.
// Optional cycle counter enabled by defining IF_EXEC_CYCLE_COUNT_EN.
module if_exec_controller
  import if_ctrl_pkg::*;
#(
  parameter int                        NB_INSTRUCTION = 32,
  parameter logic [NB_INSTRUCTION-1:0] HALT_OPCODE    = NB_INSTRUCTION'(HALT_OPCODE_DEF),
  parameter int                        DRAIN_CYCLES   = DRAIN_CYCLES_DEF
`ifdef IF_EXEC_CYCLE_COUNT_EN
  , parameter int                      NB_CYCLE_CNT   = 32
`endif
) (
  input logic                 i_clock,
  input logic                 i_reset,
  if_exec_controller_if.slave bus
);
  localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("DRAIN_CYCLES must be at least 1");
  end

  ctrl_state_e state, state_next;
  logic        halt_hit, cnt_load, cnt_dec, cnt_zero;
  logic        pc_en, pipe_en;

  assign halt_hit = (bus.i_instruction == HALT_OPCODE);

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_program_loaded && bus.i_run)       state_next = RUN;
        else if (bus.i_program_loaded && bus.i_step) state_next = STEP;
      end
      RUN: begin
        if (halt_hit) begin
          state_next = DRAIN;
          cnt_load   = 1'b1;
        end
      end
      STEP: begin
        if (halt_hit) begin
          state_next = DRAIN;
          cnt_load   = 1'b1;
        end else begin
          state_next = STEP_WAIT;
        end
      end
      STEP_WAIT: begin
        if (bus.i_run)       state_next = RUN;
        else if (bus.i_step) state_next = STEP;
      end
      DRAIN: begin
        if (cnt_zero) state_next = HALTED;
        else          cnt_dec    = 1'b1;
      end
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
    // restart overrides everything, including a HALT match this cycle
    if (bus.i_restart) begin
      state_next = IDLE;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
    end
  end

  drain_counter #(.WIDTH(CNT_W)) u_drain (
    .clk        (i_clock),
    .rst        (i_reset),
    .clear      (bus.i_restart),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (CNT_W'(DRAIN_CYCLES - 1)),
    .zero       (cnt_zero)
  );

  assign pc_en   = (state == RUN) || (state == STEP);
  assign pipe_en = pc_en || (state == DRAIN);

  assign bus.o_pc_enable       = pc_en;
  assign bus.o_read_enable     = pc_en;
  assign bus.o_pipeline_enable = pipe_en;
  assign bus.o_pc_reset        = (state == IDLE);
  assign bus.o_halted          = (state == HALTED);
  assign bus.o_busy            = pipe_en;

`ifdef IF_EXEC_CYCLE_COUNT_EN
  logic [NB_CYCLE_CNT-1:0] cycle_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || bus.i_restart)         cycle_count <= '0;
    else if (pipe_en && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
  end

  assign bus.o_cycle_count = cycle_count;
`endif
endmodule

// File: doc/if_exec_controller.md
Name: if_exec_controller

Overview:
- Sequences the instruction-fetch stage and the downstream pipeline registers.
- Drives the PC enable, PC reset and instruction-memory read enable into the fetch stage, plus a global pipeline-advance enable.
- Supports continuous run and single-step modes, detects the HALT encoding on the fetched instruction, and drains in-flight instructions before reporting halted.
- Sits between the debug/UART command unit and the fetch stage.

Parameters:
- NB_INSTRUCTION, 32, fetched-instruction width.
- HALT_OPCODE, 32'hFFFF_FFFF, instruction encoding that terminates execution.
- DRAIN_CYCLES, 4, pipeline-advance cycles after HALT fetch (ID/EX/MEM/WB).
- NB_CYCLE_CNT, 32, cycle-counter width (optional feature).

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_program_loaded  in  1  level; instruction memory holds a valid program.
- i_run  in  1  1-cycle pulse; start continuous execution.
- i_step  in  1  1-cycle pulse; execute one cycle.
- i_restart  in  1  1-cycle pulse; return to IDLE with PC reset.
- i_instruction  in  NB_INSTRUCTION  instruction output of the fetch stage.
- o_pc_enable  out  1  to fetch-stage PC enable.
- o_pc_reset  out  1  to fetch-stage PC reset.
- o_read_enable  out  1  to fetch-stage instruction-memory read enable.
- o_pipeline_enable  out  1  advance enable for IF/ID, ID/EX, EX/MEM, MEM/WB registers.
- o_halted  out  1  level; program finished and pipeline drained.
- o_busy  out  1  level; in RUN, STEP or DRAIN.
- o_cycle_count  out  NB_CYCLE_CNT  only when CYCLE_COUNT_EN is defined.

Behaviour:
- Registered FSM with states IDLE, RUN, STEP, DRAIN, HALTED. All outputs are decoded from registered state only (Moore).
- Reset: state is IDLE, drain counter is 0, o_pc_reset = 1, all other outputs are 0.
- IDLE:
  - o_pc_reset = 1; PC and pipeline are held.
  - i_run with i_program_loaded goes to RUN.
  - i_step with i_program_loaded goes to STEP.
  - i_run and i_step in the same cycle: i_run wins.
  - Pulses while i_program_loaded = 0 are ignored.
- RUN:
  - o_pc_enable = o_read_enable = o_pipeline_enable = 1 every cycle.
  - If i_instruction equals HALT_OPCODE, go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
- STEP:
  - Lasts exactly one cycle with enables = 1 (single PC/pipeline advance).
  - Next state is DRAIN if i_instruction equals HALT_OPCODE that cycle, otherwise IDLE_STEP.
  - IDLE_STEP is encoded as STEP-wait: a sub-state with all enables 0 and o_pc_reset = 0. It waits for the next i_step, which returns to STEP.
  - i_run in IDLE_STEP goes to RUN.
- DRAIN:
  - o_pc_enable = 0, o_read_enable = 0, o_pipeline_enable = 1.
  - Counter decrements each cycle; at 0 go to HALTED.
  - Exactly DRAIN_CYCLES pipeline advances occur after the HALT fetch.
  - DRAIN_CYCLES = 0 is illegal; an elaboration check fires.
- HALTED:
  - o_halted = 1; all enables are 0; PC is not reset, so the final PC stays readable.
  - i_run and i_step are ignored.
- i_restart:
  - From any state goes to IDLE next cycle; the drain counter is cleared.
  - Has priority over all other inputs, including a HALT match in the same cycle.
- o_busy = 1 in RUN, STEP and DRAIN; 0 elsewhere.
- i_reset asserted mid-RUN or mid-DRAIN: next cycle is IDLE with reset output values; no partial drain.
- HALT compare is an exact full-width equality. HALT seen in the same cycle as the RUN entry is checked only from the first RUN cycle onward.

Optional Feature:
- Macro: IF_EXEC_CYCLE_COUNT_EN.
- Defined:
  - o_cycle_count is present.
  - Cleared by reset or i_restart.
  - Increments by 1 each cycle o_pipeline_enable = 1.
  - Saturates at all-ones (no wrap).
  - Holds in HALTED.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package if_ctrl_pkg:
  - FSM state enum (IDLE, RUN, STEP, STEP_WAIT, DRAIN, HALTED).
  - HALT_OPCODE constant.
  - DRAIN_CYCLES default.
- One natural sub-module, drain_counter: loadable down-counter with a zero flag. It is reused by the debug unit for the UART byte count.
- FSM and output decode stay in if_exec_controller.

Test Plan:
- Reset then idle: i_reset = 1 for 2 cycles, then 0 with no commands -> o_pc_reset = 1, enables = 0, o_halted = 0, o_busy = 0 indefinitely.
- Continuous run: i_program_loaded = 1, i_run pulse, HALT_OPCODE presented on cycle 10 of RUN -> o_pc_enable low from the next cycle; o_pipeline_enable high for exactly 4 more cycles; then o_halted = 1.
- Single step: three i_step pulses spaced 5 cycles apart -> exactly three 1-cycle o_pc_enable/o_pipeline_enable pulses, each one cycle after its i_step; enables = 0 between pulses. With CYCLE_COUNT_EN, o_cycle_count = 3.
- Guarded start: i_run with i_program_loaded = 0 -> stays IDLE. i_run and i_step in the same cycle with loaded = 1 -> RUN (continuous enables).
- Restart priority: i_restart during DRAIN on the same cycle as counter = 1 -> IDLE next cycle, o_halted never asserted, o_pc_reset = 1.
- Mid-run reset: i_reset during RUN -> next cycle IDLE with reset values. A subsequent i_run resumes with a fresh drain count of 4.
